quad_decoder: RTL and testbench

- Decodes a two-phase quadrature encoder (A/B) into direction and step events, and keeps a signed position count.
- It is the producer side of the up/down counting interface: its up_down/step outputs feed a counting block like the existing up/down counter, and it also holds its own wide position register.
- Sits between the off-chip encoder pins and the control logic.

---
 rtl/quad_decoder_pkg.sv | 36 +++
 rtl/quad_sync_filter.sv | 51 +++++
 rtl/quad_decoder.sv | 97 +++++++++
 tb/tb_quad_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared types for the quadrature decoder: phase-state encodings, step classes
// and the transition classifier used by the decode stage.
package quad_decoder_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN,
        STEP_ILLEGAL
    } step_e;

    // Up order is 00->01->11->10->00; an inverted pair means both phases moved.
    function automatic step_e classify_step(input logic [1:0] prev_ab, input logic [1:0] ab);
        logic [1:0] up_next;
        case (prev_ab)
            ST_00:   up_next = ST_01;
            ST_01:   up_next = ST_11;
            ST_11:   up_next = ST_10;
            default: up_next = ST_00;
        endcase
        if (ab == prev_ab)
            return STEP_NONE;
        else if (ab == ~prev_ab)
            return STEP_ILLEGAL;
        else if (ab == up_next)
            return STEP_UP;
        else
            return STEP_DOWN;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Per-phase 2-FF synchronizer with an optional stable-run glitch filter,
// enabled by defining QUAD_DECODER_GLITCH_FILTER_EN.
module quad_sync_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("quad_sync_filter: FILT_LEN must be in 2..15");
    end

    logic [1:0] sync;

    // NOTE: non-blocking assignments so each flop captures its pre-edge input;
    // blocking here would collapse the two synchronizer stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sync <= 2'b00;
        else
            sync <= {sync[0], din};
    end

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
    logic [3:0] run_cnt;
    logic       filt;

    // run_cnt counts consecutive cycles the synchronized input disagrees with filt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync[1] == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == 4'(FILT_LEN - 1)) begin
            run_cnt <= '0;
            filt    <= sync[1];
        end else begin
            run_cnt <= run_cnt + 4'd1;
        end
    end

    assign dout = filt;
`else
    assign dout = sync[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: step/direction pulses, illegal-transition flags and a
// wrapping signed position count. Glitch filter via QUAD_DECODER_GLITCH_FILTER_EN.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             qa,
    input  logic             qb,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             step,
    output logic             err,
    output logic             err_flag
);

    // Front-end flops reset to 0, so decoding waits until the encoder's real
    // level has propagated through them; a non-00 power-up position never counts.
`ifdef QUAD_DECODER_GLITCH_FILTER_EN
    localparam int ARM_DLY = 2 + FILT_LEN;
`else
    localparam int ARM_DLY = 2;
`endif

    logic       a_s, b_s;
    logic [1:0] ab, prev_ab;
    logic       armed;
    logic [4:0] arm_cnt;
    step_e      step_cls;

    quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_a (
        .clk   (clk),
        .reset (reset),
        .din   (qa),
        .dout  (a_s)
    );

    quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync_b (
        .clk   (clk),
        .reset (reset),
        .din   (qb),
        .dout  (b_s)
    );

    assign ab       = {a_s, b_s};
    assign step_cls = classify_step(prev_ab, ab);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ab  <= ST_00;
            armed    <= 1'b0;
            arm_cnt  <= '0;
            count    <= '0;
            up_down  <= 1'b0;
            step     <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            prev_ab <= ab;
            step    <= 1'b0;
            err     <= 1'b0;
            if (!armed) begin
                arm_cnt <= arm_cnt + 5'd1;
                if (arm_cnt == 5'(ARM_DLY))
                    armed <= 1'b1;
            end else begin
                case (step_cls)
                    STEP_UP: begin
                        step    <= 1'b1;
                        up_down <= 1'b1;
                        count   <= count + WIDTH'(1);
                    end
                    STEP_DOWN: begin
                        step    <= 1'b1;
                        up_down <= 1'b0;
                        count   <= count - WIDTH'(1);
                    end
                    STEP_ILLEGAL: begin
                        err      <= 1'b1;
                        err_flag <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // clear overrides count/err_flag only; pulses and direction still update.
            if (clear) begin
                count    <= '0;
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (WIDTH=8, FILT_LEN=4).
module tb_quad_decoder;

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = LAT + 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       qa = 1'b0;
    logic       qb = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] count;
    logic       up_down, step, err, err_flag;

    int checks = 0;
    int errors = 0;
    int step_cnt = 0;
    int err_cnt = 0;
    int s0, e0;

    quad_decoder #(.WIDTH(8), .FILT_LEN(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .qa       (qa),
        .qb       (qb),
        .clear    (clear),
        .count    (count),
        .up_down  (up_down),
        .step     (step),
        .err      (err),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step) step_cnt++;
        if (err)  err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ab(input logic [1:0] v, input int hold);
        {qa, qb} = v;
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] down_seq [6];
        down_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};

        #2 reset = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_up_down", up_down, 0);
        check("rst_step", step, 0);
        check("rst_err", err, 0);
        check("rst_err_flag", err_flag, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (HOLD) @(negedge clk);

        // Full up cycle
        s0 = step_cnt; e0 = err_cnt;
        drive_ab(2'b01, HOLD); drive_ab(2'b11, HOLD);
        drive_ab(2'b10, HOLD); drive_ab(2'b00, HOLD);
        check("up_steps", step_cnt - s0, 4);
        check("up_count", count, 8'h04);
        check("up_dir", up_down, 1);
        check("up_err", err_cnt - e0, 0);

        // Six down transitions from 4
        s0 = step_cnt;
        for (int i = 0; i < 6; i++) drive_ab(down_seq[i], HOLD);
        check("dn_steps", step_cnt - s0, 6);
        check("dn_count", count, 8'hFE);
        check("dn_dir", up_down, 0);

        // Wrap around zero
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("clr_idle_count", count, 0);
        drive_ab(2'b01, HOLD);
        check("wrap_dn_ff", count, 8'hFF);
        drive_ab(2'b11, HOLD);
        check("wrap_up_00", count, 8'h00);
        drive_ab(2'b01, HOLD);
        check("wrap_dn_ff2", count, 8'hFF);

        // Illegal jump 00->11
        drive_ab(2'b00, HOLD);
        check("pre_ill_count", count, 8'hFE);
        s0 = step_cnt; e0 = err_cnt;
        drive_ab(2'b11, HOLD);
        check("ill_err_pulses", err_cnt - e0, 1);
        check("ill_err_flag", err_flag, 1);
        check("ill_count", count, 8'hFE);
        check("ill_steps", step_cnt - s0, 0);
        check("ill_dir", up_down, 0);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        check("clr_err_flag", err_flag, 0);
        check("clr_count", count, 0);

        // clear on the same edge as an up step (11->10), also pins latency
        {qa, qb} = 2'b10;
        repeat (LAT) @(negedge clk);
        check("lat_early_step", step, 0);
        clear = 1'b1;
        @(negedge clk);
        check("clr_step_step", step, 1);
        check("clr_step_count", count, 0);
        check("clr_step_dir", up_down, 1);
        clear = 1'b0;
        repeat (3) @(negedge clk);

        // Plain latency, 10->00 up
        {qa, qb} = 2'b00;
        repeat (LAT) @(negedge clk);
        check("lat2_early_step", step, 0);
        @(negedge clk);
        check("lat2_step", step, 1);
        check("lat2_count", count, 8'h01);
        repeat (3) @(negedge clk);

        // Encoder at 11 through reset: no count on arming
        reset = 1'b0;
        {qa, qb} = 2'b11;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        s0 = step_cnt; e0 = err_cnt;
        repeat (14) @(negedge clk);
        check("arm_steps", step_cnt - s0, 0);
        check("arm_errs", err_cnt - e0, 0);
        check("arm_count", count, 0);
        drive_ab(2'b10, HOLD);
        check("arm_up_count", count, 8'h01);
        check("arm_up_dir", up_down, 1);
        drive_ab(2'b01, HOLD);
        check("arm_ill_flag", err_flag, 1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_up_down", up_down, 0);
        check("async_step", step, 0);
        check("async_err", err, 0);
        check("async_err_flag", err_flag, 0);
        @(negedge clk);
        reset = 1'b1;
        s0 = step_cnt; e0 = err_cnt;
        repeat (14) @(negedge clk);
        check("rearm_steps", step_cnt - s0, 0);
        check("rearm_errs", err_cnt - e0, 0);
        drive_ab(2'b00, HOLD);
        check("rearm_dn_count", count, 8'hFF);
        check("rearm_dn_dir", up_down, 0);

`ifdef QUAD_DECODER_GLITCH_FILTER_EN
        // Short pulse on qa is swallowed
        s0 = step_cnt; e0 = err_cnt;
        {qa, qb} = 2'b10;
        repeat (2) @(negedge clk);
        {qa, qb} = 2'b00;
        repeat (12) @(negedge clk);
        check("filt_glitch_steps", step_cnt - s0, 0);
        check("filt_glitch_errs", err_cnt - e0, 0);

        // Stable change reaches step after edge N+6
        {qa, qb} = 2'b01;
        repeat (6) @(negedge clk);
        check("filt_early_step", step, 0);
        @(negedge clk);
        check("filt_step", step, 1);
        check("filt_count", count, 8'h00);
        repeat (3) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
